// File: rtl/mem_pkg.sv
// Shared definitions for the two-port RAM arbiter: widths, FSM states and port ids.
// Optional build macro ARB_ROUND_ROBIN_EN (used by mem_arbiter) selects round-robin arbitration.
package mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RWAIT  = 2'd2
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between instruction-fetch and load/store requesters.
// A lone requester always wins; on a tie the port that was not granted last wins.
// Tying last_ptr to 0 turns this into fixed priority with port 1 on top.
module mem_arb_pick
    import mem_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_ptr,
    output logic any_req,
    output logic winner
);

    // Choose the port to serve this IDLE cycle
    always_comb begin
        any_req = req0 | req1;
        winner  = PORT_LS;
        if (req0 && req1) begin
            winner = ~last_ptr;
        end else if (req0) begin
            winner = PORT_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester controller for the single-port 2^16 x 32 RAM.
// One request in flight at a time; reads return through a registered response.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (port 1 first).
module mem_arbiter
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_input,
    output logic              ram_write_enable,
    output logic              ram_read_enable,
    input  logic [DATA_W-1:0] ram_data_output
);

    state_t            state;
    state_t            next_state;
    logic              any_req;
    logic              winner;
    logic              last_ptr;
    logic              take;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              cmd_we;
    logic              cmd_port;

    mem_arb_pick u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_ptr (last_ptr),
        .any_req  (any_req),
        .winner   (winner)
    );

    // A request is accepted only in IDLE and never while reset is held
    assign take = (state == IDLE) && !rst && any_req;

`ifdef ARB_ROUND_ROBIN_EN
    // Remember which port was granted last so ties alternate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ptr <= 1'b0;
        end else if (take) begin
            last_ptr <= winner;
        end
    end
`else
    assign last_ptr = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: writes take one RAM cycle, reads add a capture cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = ACCESS;
            ACCESS:  next_state = cmd_we ? IDLE : RWAIT;
            RWAIT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: grants in IDLE, RAM enables only during ACCESS
    always_comb begin
        gnt0             = take && (winner == PORT_IF);
        gnt1             = take && (winner == PORT_LS);
        busy             = (state != IDLE);
        ram_write_enable = (state == ACCESS) && cmd_we;
        ram_read_enable  = (state == ACCESS) && !cmd_we;
    end

    // Latch the winning request; these registers also drive the RAM address/data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_we    <= 1'b0;
            cmd_port  <= PORT_IF;
        end else if (take) begin
            cmd_addr  <= (winner == PORT_LS) ? addr1  : addr0;
            cmd_wdata <= (winner == PORT_LS) ? wdata1 : wdata0;
            cmd_we    <= (winner == PORT_LS) ? we1    : we0;
            cmd_port  <= winner;
        end
    end

    assign ram_address    = cmd_addr;
    assign ram_data_input = cmd_wdata;

    // Capture RAM output in RWAIT and strobe rvalid of the owning port for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            if (state == RWAIT) begin
                if (cmd_port == PORT_LS) begin
                    rdata1  <= ram_data_output;
                    rvalid1 <= 1'b1;
                end else begin
                    rdata0  <= ram_data_output;
                    rvalid0 <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural RAM and a transaction-level model.
// Honours ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [31:0] rdata0, rdata1;
    logic [15:0] ram_address;
    logic [31:0] ram_data_input;
    logic        ram_write_enable, ram_read_enable;
    wire  [31:0] ram_data_output;

    mem_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .req0             (req0),
        .req1             (req1),
        .we0              (we0),
        .we1              (we1),
        .addr0            (addr0),
        .addr1            (addr1),
        .wdata0           (wdata0),
        .wdata1           (wdata1),
        .gnt0             (gnt0),
        .gnt1             (gnt1),
        .rvalid0          (rvalid0),
        .rvalid1          (rvalid1),
        .rdata0           (rdata0),
        .rdata1           (rdata1),
        .busy             (busy),
        .ram_address      (ram_address),
        .ram_data_input   (ram_data_input),
        .ram_write_enable (ram_write_enable),
        .ram_read_enable  (ram_read_enable),
        .ram_data_output  (ram_data_output)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port RAM: cleared on reset, registered read, Z when not reading
    logic [31:0] ram_arr [0:65535];
    logic [31:0] ram_q;
    logic        ram_q_ok;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 65536; i++) ram_arr[i] <= '0;
            ram_q    <= '0;
            ram_q_ok <= 1'b0;
        end else begin
            if (ram_write_enable) ram_arr[ram_address] <= ram_data_input;
            if (ram_read_enable) ram_q <= ram_arr[ram_address];
            ram_q_ok <= ram_read_enable;
        end
    end
    assign ram_data_output = ram_q_ok ? ram_q : 32'hzzzzzzzz;

    // Reference model state
    typedef struct {
        int          port;
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    rsp_t        exp_q [$];
    logic [31:0] model_mem [int];
    logic        pend  [2];
    logic        pwe   [2];
    logic [15:0] paddr [2];
    logic [31:0] pdata [2];
    int          cycle;
    int          free_cycle;
    int          total;
    int          bad;
`ifdef ARB_ROUND_ROBIN_EN
    int          last_gnt;
`endif

    // Compare one observed value against its expected value
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Queue a request on a port; it is held until the model sees it granted
    task automatic issue(input int p, input logic w, input logic [15:0] a, input logic [31:0] d);
        pend[p]  = 1'b1;
        pwe[p]   = w;
        paddr[p] = a;
        pdata[p] = d;
    endtask

    // Advance one cycle: drive pending requests, predict the grant, check grant/busy
    task automatic applyStimulus();
        logic eg0, eg1, eb;
        int   w;
        int   key;
        @(posedge clk);
        #1;
        cycle++;
        req0 = pend[0]; we0 = pwe[0]; addr0 = paddr[0]; wdata0 = pdata[0];
        req1 = pend[1]; we1 = pwe[1]; addr1 = paddr[1]; wdata1 = pdata[1];
        eg0 = 1'b0;
        eg1 = 1'b0;
        eb  = (cycle < free_cycle);
        if (!eb && (pend[0] || pend[1])) begin
            if (pend[0] && pend[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
                w = (last_gnt == 1) ? 0 : 1;
`else
                w = 1;
`endif
            end else begin
                w = pend[1] ? 1 : 0;
            end
`ifdef ARB_ROUND_ROBIN_EN
            last_gnt = w;
`endif
            if (w == 1) eg1 = 1'b1; else eg0 = 1'b1;
            key = int'(paddr[w]);
            if (pwe[w]) begin
                model_mem[key] = pdata[w];
                free_cycle = cycle + 2;
            end else begin
                exp_q.push_back('{port: w,
                                  data: model_mem.exists(key) ? model_mem[key] : 32'h0,
                                  cyc:  cycle + 3});
                free_cycle = cycle + 3;
            end
            pend[w] = 1'b0;
        end
        @(negedge clk);
        checkOutput("gnt0", {31'b0, gnt0}, {31'b0, eg0});
        checkOutput("gnt1", {31'b0, gnt1}, {31'b0, eg1});
        checkOutput("busy", {31'b0, busy}, {31'b0, eb});
    endtask

    // Run until nothing is pending or in flight, with a cycle budget
    task automatic runUntilIdle(input int max_cycles);
        int n;
        n = 0;
        while ((pend[0] || pend[1] || exp_q.size() > 0 || cycle < free_cycle) && n < max_cycles) begin
            applyStimulus();
            n++;
        end
        checkOutput("drain_in_budget", {31'b0, n < max_cycles}, 32'd1);
    endtask

    // Step until port p has been granted, with a cycle budget
    task automatic waitGrant(input int p, input int max_cycles);
        int n;
        n = 0;
        while (pend[p] && n < max_cycles) begin
            applyStimulus();
            n++;
        end
        checkOutput("grant_in_budget", {31'b0, n < max_cycles}, 32'd1);
    endtask

    // Assert reset now, check every output is cleared, then release away from the clock edge
    task automatic resetPulse();
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        #2;
        checkOutput("rst_gnt0", {31'b0, gnt0}, 32'd0);
        checkOutput("rst_gnt1", {31'b0, gnt1}, 32'd0);
        checkOutput("rst_rvalid0", {31'b0, rvalid0}, 32'd0);
        checkOutput("rst_rvalid1", {31'b0, rvalid1}, 32'd0);
        checkOutput("rst_rdata0", rdata0, 32'd0);
        checkOutput("rst_rdata1", rdata1, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_we", {31'b0, ram_write_enable}, 32'd0);
        checkOutput("rst_re", {31'b0, ram_read_enable}, 32'd0);
        checkOutput("rst_addr", {16'b0, ram_address}, 32'd0);
        checkOutput("rst_din", ram_data_input, 32'd0);
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        exp_q.delete();
        model_mem.delete();
`ifdef ARB_ROUND_ROBIN_EN
        last_gnt = 0;
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        free_cycle = cycle + 1;
    endtask

    // Response monitor: enable exclusivity every cycle, pop and compare on each rvalid
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("en_exclusive", {31'b0, ram_write_enable & ram_read_enable}, 32'd0);
            if (rvalid0 || rvalid1) begin
                checkOutput("rvalid_onehot", {31'b0, rvalid0 & rvalid1}, 32'd0);
                checkOutput("rsp_expected", {31'b0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    checkOutput("rsp_port", {31'b0, rvalid1}, e.port);
                    checkOutput("rsp_data", rvalid1 ? rdata1 : rdata0, e.data);
                    checkOutput("rsp_cycle", cycle, e.cyc);
                end
            end
        end
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        total = 0;
        bad   = 0;
        cycle = 0;
        free_cycle = 0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        pwe[0] = 1'b0; pwe[1] = 1'b0;
        paddr[0] = '0; paddr[1] = '0;
        pdata[0] = '0; pdata[1] = '0;
        resetPulse();

        $display("[TB] write then read on port 1");
        issue(1, 1'b1, 16'h0010, 32'hDEADBEEF);
        runUntilIdle(20);
        issue(1, 1'b0, 16'h0010, 32'h0);
        runUntilIdle(20);
        checkOutput("rdata1_deadbeef", rdata1, 32'hDEADBEEF);

        $display("[TB] tie rounds");
        for (int r = 0; r < 4; r++) begin
            issue(0, 1'b0, 16'h0010, 32'h0);
            issue(1, 1'b0, 16'h0010, 32'h0);
            runUntilIdle(30);
        end

        $display("[TB] back-to-back writes on port 0");
        for (int i = 0; i < 4; i++) begin
            issue(0, 1'b1, 16'(i), 32'hA5A50000 + 32'(i));
            waitGrant(0, 10);
        end
        for (int i = 0; i < 4; i++) begin
            issue(0, 1'b0, 16'(i), 32'h0);
            waitGrant(0, 10);
        end
        runUntilIdle(20);
        checkOutput("rdata0_last_readback", rdata0, 32'hA5A50003);

        $display("[TB] top-of-range address");
        issue(1, 1'b1, 16'hFFFF, 32'h12345678);
        runUntilIdle(20);
        issue(0, 1'b0, 16'hFFFF, 32'h0);
        runUntilIdle(20);
        checkOutput("rdata0_ffff", rdata0, 32'h12345678);

        $display("[TB] reset during RWAIT");
        issue(0, 1'b0, 16'h0001, 32'h0);
        waitGrant(0, 10);
        applyStimulus();
        @(posedge clk);
        #1;
        resetPulse();
        for (int i = 0; i < 4; i++) applyStimulus();
        issue(0, 1'b0, 16'h0001, 32'h0);
        runUntilIdle(20);
        checkOutput("rdata0_after_rst", rdata0, 32'h0);

        $display("[TB] random traffic");
        for (int c = 0; c < 2000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(2) == 0) begin
                    issue(p, 1'($urandom_range(1)),
                          ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom_range(15)),
                          $urandom);
                end
            end
            applyStimulus();
        end
        runUntilIdle(40);
        checkOutput("rsp_queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester controller that shares the single-port 2^16 x 32 RAM between the instruction-fetch port (port 0) and the load/store port (port 1). It accepts one request at a time, drives the RAM's write/read enables for exactly one cycle, and returns read data to the originating port through a registered response. It sits between the CPU pipeline and the RAM, and is the only block allowed to drive the RAM control inputs.

## Interface
- ADDR_W, 16, RAM address width
- DATA_W, 32, RAM data width
- clk  in  1  rising-edge clock, shared with RAM
- rst  in  1  asynchronous active-high reset, shared with RAM
- req0 / req1  in  1  request valid per port; held until granted
- we0 / we1  in  1  1 = write, 0 = read; qualified by reqN
- addr0 / addr1  in  ADDR_W  request address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  request accepted this cycle (combinational, IDLE only)
- rvalid0 / rvalid1  out  1  one-cycle read-response strobe
- rdata0 / rdata1  out  DATA_W  read data; valid only while rvalidN = 1
- busy  out  1  high in any state other than IDLE
- ram_address  out  ADDR_W  to RAM address
- ram_data_input  out  DATA_W  to RAM data_input
- ram_write_enable / ram_read_enable  out  1  to RAM enables; never both high
- ram_data_output  in  DATA_W  from RAM; may be Z outside read cycles

## Operation
- States: IDLE, ACCESS, RWAIT.
- IDLE: if any reqN is high, select a winner, assert its gntN, and latch addr/wdata/we/port id into command registers → ACCESS. Otherwise stay in IDLE.
- ACCESS: drive ram_address and ram_data_input from the command registers. Assert ram_write_enable if we = 1, else ram_read_enable.
  - Write → IDLE.
  - Read → RWAIT.
- RWAIT: RAM enables low. ram_data_output holds the word captured at the ACCESS edge. At the RWAIT edge, register it into rdata of the owning port, set that rvalid → IDLE.
- rvalidN is high for exactly one cycle and then clears. rdataN holds its last value until the next read response for that port.
- Default arbitration is fixed priority: port 1 beats port 0.
- The non-winning request stays pending and is not granted in the same IDLE cycle.
- ram_address and ram_data_input stay at the last command values outside ACCESS. ram_data_output is sampled only in RWAIT.
- Reset (any time, including mid-ACCESS or RWAIT):
  - state → IDLE; all command registers, rdataN, rvalidN, gntN, RAM enables and busy → 0.
  - An in-flight read response is discarded.
  - The RAM clears its contents on the same reset.

## Timing
- Grant at cycle T (IDLE) → RAM enable high in cycle T+1.
- Write: RAM updated at the end of T+1; next grant possible at T+2.
- Read: rvalidN high in cycle T+3, which is an IDLE cycle; a new grant may coincide with it.
- Sustained throughput: 1 write per 2 cycles; 1 read per 3 cycles.
- First cycle after rst deasserts: IDLE, grant possible.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
  - A 1-bit last-grant pointer resets to 0, so port 1 wins the first tie.
  - On a tie, the port not granted last wins.
  - A lone requester always wins, regardless of the pointer.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, port 1 > port 0; no pointer register.

## Structure
- Shared package mem_pkg: ADDR_W, DATA_W, the state enum (IDLE, ACCESS, RWAIT), and the port-id constants PORT_IF = 0, PORT_LS = 1.
- One sub-module, mem_arb_pick: combinational winner selection from req0, req1 and the pointer. The pointer input is tied off when ARB_ROUND_ROBIN_EN is undefined.

## Test plan
- Port 1 writes 32'hDEADBEEF to 16'h0010, then port 1 reads 16'h0010 → rvalid1 at T+3, rdata1 = 32'hDEADBEEF; rvalid0 stays 0.
- req0 and req1 both high in one IDLE cycle, both reads → fixed: gnt1 first, gnt0 at the following IDLE. RR: alternation over 4 back-to-back tie rounds = 1,0,1,0.
- Back-to-back writes from port 0 to 16'h0000..16'h0003 → a grant every 2 cycles; readback returns the written data.
- Assert rst in the RWAIT of a read → rvalid never pulses, state IDLE, all outputs 0; a subsequent read of any address returns 32'h0.
- Random reqN/weN stimulus for 2000 cycles → ram_write_enable and ram_read_enable never both high; exactly one gnt per ACCESS; every granted read produces exactly one rvalid on the correct port.
- Read of 16'hFFFF after a write of 32'h12345678 → rdata = 32'h12345678 (top-of-range address).
